// File: rtl/cpu_multicycle_if.sv
// Instruction-memory port of the multi-cycle core.
// The master (the core) raises imem_req and drives imem_addr; the slave
// (the instruction memory) answers with imem_valid and imem_data.
interface cpu_multicycle_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/cpu_multicycle.sv
// Multi-cycle 16-bit-instruction core: IDLE -> FETCH -> EXEC loop, with HALT.
// Instruction word layout is src1[15:12] | src2[11:8] | dest[7:4] | func[3:0].
// Register R0 always reads as zero, and writes to it are dropped.
// Optional feature macro CPU_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module cpu_multicycle #(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_multicycle_if.master      imem,
    output logic [PC_W-1:0]       pc,
    output logic                  retire,
    output logic                  halted,
    input  logic [3:0]            dbg_raddr,
`ifdef CPU_RETIRE_CNT_EN
    output logic [31:0]           retire_cnt,
`endif
    output logic [DATA_W-1:0]     dbg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       ir;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] regs [0:15];
    logic              req;

    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [3:0]        dest;
    logic [3:0]        func;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic              wr_en;
    logic              shift_oob;
    logic [PC_W-1:0]   pc_next;

    assign src1 = ir[15:12];
    assign src2 = ir[11:8];
    assign dest = ir[7:4];
    assign func = ir[3:0];

    assign op_a      = (src1 == 4'd0) ? '0 : regs[src1];
    assign op_b      = (src2 == 4'd0) ? '0 : regs[src2];
    assign shift_oob = (op_b >= DATA_W'(DATA_W));

    // The request is decoded from state, so an async reset drops it at once.
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign dbg_rdata      = (dbg_raddr == 4'd0) ? '0 : regs[dbg_raddr];

    // State register; reset returns the core to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; FETCH waits indefinitely for imem_valid.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: begin
                req = 1'b1;
                if (imem.imem_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                retire     = 1'b1;
                state_next = (func == 4'hF) ? ST_HALT : ST_FETCH;
            end
            default:  state_next = ST_HALT;
        endcase
    end

    // ALU, immediate load and branch target selection for the latched instruction.
    always_comb begin
        result  = '0;
        wr_en   = 1'b0;
        pc_next = pc_q + PC_W'(1);
        case (func)
            4'h0: begin result = op_a + op_b;                          wr_en = 1'b1; end
            4'h1: begin result = op_a - op_b;                          wr_en = 1'b1; end
            4'h2: begin result = op_a & op_b;                          wr_en = 1'b1; end
            4'h3: begin result = op_a | op_b;                          wr_en = 1'b1; end
            4'h4: begin result = op_a ^ op_b;                          wr_en = 1'b1; end
            4'h5: begin result = shift_oob ? '0 : (op_a << op_b);      wr_en = 1'b1; end
            4'h6: begin result = shift_oob ? '0 : (op_a >> op_b);      wr_en = 1'b1; end
            4'h7: begin result = DATA_W'(op_a < op_b);                 wr_en = 1'b1; end
            4'h8: begin result = DATA_W'(ir[15:8]);                    wr_en = 1'b1; end
            4'h9: begin
                if (op_a == '0) begin
                    pc_next = PC_W'(op_b);
                end
            end
            4'hA: pc_next = PC_W'(op_a);
            4'hF: pc_next = pc_q;
            default: ;
        endcase
    end

    // Architectural state: IR capture in FETCH, writeback and pc update in EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= PC_W'(RESET_PC);
            ir     <= '0;
            halted <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == ST_FETCH && imem.imem_valid) begin
                ir <= imem.imem_data;
            end
            if (state == ST_EXEC) begin
                pc_q <= pc_next;
                if (wr_en && dest != 4'd0) begin
                    regs[dest] <= result;
                end
                if (func == 4'hF) begin
                    halted <= 1'b1;
                end
            end
        end
    end

`ifdef CPU_RETIRE_CNT_EN
    // Free-running count of retired instructions, wrapping at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: directed programs plus a random
// program run against an instruction-level reference model.
module tb_cpu_multicycle;

    localparam int DATA_W = 16;
    localparam int PC_W   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [PC_W-1:0]   pc;
    logic              retire;
    logic              halted;
    logic [3:0]        dbg_raddr = 4'd0;
    logic [DATA_W-1:0] dbg_rdata;
`ifdef CPU_RETIRE_CNT_EN
    logic [31:0]       retire_cnt;
`endif

    cpu_multicycle_if #(.PC_W(PC_W)) imem_bus();

    cpu_multicycle #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem      (imem_bus),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted),
        .dbg_raddr (dbg_raddr),
`ifdef CPU_RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .dbg_rdata (dbg_rdata)
    );

    logic [15:0]     mem [0:255];
    int              valid_mode;
    int              cycles;
    int              check_cnt;
    int              fail_cnt;
    int              last_retire_cycle;
    logic [15:0]     m_regs [0:15];
    logic [PC_W-1:0] m_pc;
    logic            m_halted;
    int              m_retires;

    assign imem_bus.imem_data = mem[imem_bus.imem_addr[7:0]];

    initial forever #5 clk = ~clk;

    initial begin
        cycles = 0;
        forever @(posedge clk) cycles++;
    end

    // Memory ready pattern: 0 = always valid, 1 = random, 2 = never valid.
    initial begin
        imem_bus.imem_valid = 1'b0;
        forever begin
            @(negedge clk);
            case (valid_mode)
                0:       imem_bus.imem_valid = 1'b1;
                2:       imem_bus.imem_valid = 1'b0;
                default: imem_bus.imem_valid = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_pc      = '0;
        m_halted  = 1'b0;
        m_retires = 0;
    endtask

    // Pulse reset, check the reset state, then release with the given memory pattern.
    task automatic applyStimulus(input int mode);
        reset      = 1'b0;
        valid_mode = mode;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_req", imem_bus.imem_req, 0);
        checkOutput("rst_retire", retire, 0);
        checkOutput("rst_halted", halted, 0);
        dbg_raddr = 4'($urandom_range(1, 15));
        #1;
        checkOutput("rst_reg", dbg_rdata, 0);
`ifdef CPU_RETIRE_CNT_EN
        checkOutput("rst_retire_cnt", retire_cnt, 0);
`endif
        reset = 1'b1;
    endtask

    // Reference semantics of one instruction at the model pc.
    task automatic model_exec();
        logic [15:0] ins;
        longint      a, b, res;
        logic [3:0]  f, d;
        bit          wb;
        ins = mem[m_pc[7:0]];
        a   = longint'(m_regs[ins[15:12]]);
        b   = longint'(m_regs[ins[11:8]]);
        d   = ins[7:4];
        f   = ins[3:0];
        res = 0;
        wb  = (f <= 4'h8);
        case (f)
            4'h0: res = (a + b) % 65536;
            4'h1: res = (a - b + 65536) % 65536;
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = (b >= 16) ? 0 : (a * (longint'(1) << b)) % 65536;
            4'h6: res = (b >= 16) ? 0 : a / (longint'(1) << b);
            4'h7: res = (a < b) ? 1 : 0;
            4'h8: res = longint'(ins[15:8]);
            default: res = 0;
        endcase
        if (wb && d != 4'd0) m_regs[d] = res[15:0];
        if (f == 4'h9)      m_pc = (a == 0) ? b[PC_W-1:0] : m_pc + 16'd1;
        else if (f == 4'hA) m_pc = a[PC_W-1:0];
        else if (f == 4'hF) m_halted = 1'b1;
        else                m_pc = m_pc + 16'd1;
        m_retires++;
    endtask

    // Wait for one retire, then compare pc, flags and registers with the model.
    task automatic step_check(input bit check_rate);
        int         waited;
        logic [3:0] d;
        logic [3:0] r;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (retire !== 1'b1 && waited < 100);
        if (retire !== 1'b1) begin
            checkOutput("retire_timeout", 0, 1);
            return;
        end
        if (check_rate) checkOutput("retire_interval", 64'(cycles - last_retire_cycle), 2);
        last_retire_cycle = cycles;
        checkOutput("pc_at_exec", pc, m_pc);
        d = mem[m_pc[7:0]][7:4];
        model_exec();
        dbg_raddr = d;
        @(posedge clk);
        #1;
        checkOutput("pc_after", pc, m_pc);
        checkOutput("halted", halted, m_halted);
        checkOutput("reg_dest", dbg_rdata, m_regs[d]);
        r = 4'($urandom_range(0, 15));
        dbg_raddr = r;
        #1;
        checkOutput("reg_rand", dbg_rdata, m_regs[r]);
`ifdef CPU_RETIRE_CNT_EN
        checkOutput("retire_cnt", retire_cnt, 64'(m_retires));
`endif
    endtask

    initial begin
        int waited;
        check_cnt         = 0;
        fail_cnt          = 0;
        last_retire_cycle = 0;
        valid_mode        = 0;

        // Directed program: arithmetic, R0 discard, both BEQZ outcomes, JMP, HALT at 7.
        for (int i = 0; i < 256; i++) mem[i] = 16'h000B;
        mem[0]     = 16'h0518;
        mem[1]     = 16'h0328;
        mem[2]     = 16'h1230;
        mem[3]     = 16'h0141;
        mem[4]     = 16'h7708;
        mem[5]     = 16'h4058;
        mem[6]     = 16'h0509;
        mem[7]     = 16'h000F;
        mem[8'h40] = 16'h1509;
        mem[8'h41] = 16'h0768;
        mem[8'h42] = 16'h600A;

        applyStimulus(0);
        for (int i = 0; i < 3; i++) step_check(i > 0);
        dbg_raddr = 4'd3;
        #1;
        checkOutput("add_r3", dbg_rdata, 16'd8);
        checkOutput("add_pc", pc, 16'd3);
        step_check(1);
        dbg_raddr = 4'd4;
        #1;
        checkOutput("sub_r4", dbg_rdata, 16'hFFFB);
        step_check(1);
        dbg_raddr = 4'd0;
        #1;
        checkOutput("r0_zero", dbg_rdata, 16'h0);
        step_check(1);
        step_check(1);
        checkOutput("beqz_taken", pc, 16'h0040);
        step_check(1);
        checkOutput("beqz_not_taken", pc, 16'h0041);
        for (int i = 0; i < 3; i++) step_check(1);
        checkOutput("halt_flag", halted, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("halt_req", imem_bus.imem_req, 0);
            checkOutput("halt_pc", pc, 16'd7);
            checkOutput("halt_retire", retire, 0);
        end

        // Stalled fetch: memory never valid, then resume after reset.
        applyStimulus(2);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_req", imem_bus.imem_req, 1);
            checkOutput("stall_addr", imem_bus.imem_addr, 0);
            checkOutput("stall_retire", retire, 0);
            checkOutput("stall_pc", pc, 0);
        end
        valid_mode = 0;
        step_check(0);
        step_check(0);

        // Reset asserted during the EXEC of ADD R3.
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (retire !== 1'b1 && waited < 100);
        checkOutput("exec_reached", retire, 1);
        checkOutput("exec_pc", pc, 16'd2);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_exec_req", imem_bus.imem_req, 0);
        checkOutput("rst_exec_retire", retire, 0);
        model_reset();
        @(negedge clk);
        dbg_raddr = 4'd3;
        #1;
        checkOutput("rst_exec_r3", dbg_rdata, 16'h0);
        reset = 1'b1;

        // Random program with random memory readiness; no HALT opcodes.
        for (int i = 0; i < 256; i++) begin
            mem[i] = {12'($urandom), 4'($urandom_range(0, 14))};
        end
        applyStimulus(1);
        repeat (200) step_check(0);

        // Ten NOPs then HALT: eleven retires in total.
        for (int i = 0; i < 256; i++) mem[i] = 16'h000C;
        mem[10] = 16'h000F;
        applyStimulus(0);
        repeat (11) step_check(0);
        checkOutput("final_halted", halted, 1);
        checkOutput("final_pc", pc, 16'd10);
`ifdef CPU_RETIRE_CNT_EN
        checkOutput("retire_cnt_11", retire_cnt, 32'd11);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle 16-bit core.
- Fetches 16-bit instructions (src1|src2|dest|func, 4 bits each) over a valid-handshaked instruction-memory port.
- Executes each instruction with an internal register file and ALU. DATA_W and PC_W are generic.
- Adds immediate load, conditional/unconditional jumps, HALT, R0-hardwired-zero and a debug register read port.

Parameters:
- DATA_W, 16: register/ALU data width; legal range 8..64.
- PC_W, 16: program counter and imem_addr width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  out  1  fetch request; high for the whole FETCH state.
- imem_addr  out  PC_W  fetch address; equals pc while imem_req=1.
- imem_valid  in  1  instruction valid; sampled only while imem_req=1.
- imem_data  in  16  instruction word; captured when imem_req & imem_valid.
- pc  out  PC_W  current program counter.
- retire  out  1  one-cycle pulse per executed instruction, HALT included.
- halted  out  1  high once HALT has executed.
- dbg_raddr  in  4  debug register select.
- dbg_rdata  out  DATA_W  combinational R[dbg_raddr]; reads 0 for R0.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. Reset forces IDLE. IDLE->FETCH unconditionally on the next edge.
- FETCH: imem_req=1, imem_addr=pc. Remains in FETCH while imem_valid=0, with no limit.
  - On imem_valid=1: IR<=imem_data, go to EXEC.
- EXEC (1 cycle): reads a=R[src1] and b=R[src2], executes, writes back, updates pc, retire=1. Next state is FETCH, or HALT for func 0xF.
- Minimum throughput: 2 cycles per instruction (imem_valid already high on entry to FETCH).
- func encoding (results are DATA_W bits, modulo 2^DATA_W):
  - 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR.
  - 5 SHL a<<b; 6 SHR a>>b (logical). If b>=DATA_W the result is 0.
  - 7 SLTU: result 1 if a<b unsigned, else 0.
  - 8 LDI: R[dest] <= zero-extended 8-bit immediate {src1,src2}.
  - 9 BEQZ: if a==0 then pc<=b[PC_W-1:0] (zero-extended if DATA_W<PC_W), else pc+1. No writeback.
  - 0xA JMP: pc<=a truncated/zero-extended to PC_W. No writeback.
  - 0xB-0xE: NOP, pc+1.
  - 0xF HALT: pc unchanged; halted<=1.
- ALU/LDI ops: R[dest] written at the end of EXEC, then pc<=pc+1. pc wraps from 2^PC_W-1 to 0.
- R0: reads always 0; writes to dest=0 are discarded.
- HALT state: imem_req=0, retire=0, all state frozen. Left only by reset.
- Reset values: state=IDLE, pc=RESET_PC, R1..R15=0, imem_req=0, retire=0, halted=0, IR=0.
- Reset asserted mid-FETCH or mid-EXEC: imem_req drops asynchronously and no writeback occurs.
- imem_valid while imem_req=0 is ignored.

Optional Feature:
- Macro: CPU_RETIRE_CNT_EN.
- Defined: adds output port retire_cnt (out, 32): counts retire pulses, resets to 0, wraps at 2^32.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- LDI R1,0x05; LDI R2,0x03; ADD R3=R1+R2 with imem_valid tied high -> dbg R3=8, pc=3, retire pulses every 2nd cycle.
- SUB R4=R0-R1 with R1=5, DATA_W=16 -> R4=0xFFFB; LDI to dest=0 -> dbg R0 stays 0.
- BEQZ src1=R0, src2=R5 with R5=0x0040 -> pc=0x0040. Repeat with src1=R1 (R1=5) -> pc=old pc+1.
- imem_valid held low 5 cycles during FETCH -> imem_req stays high, imem_addr stable, no retire, pc unchanged.
- HALT at pc=7 -> halted=1, pc stays 7, imem_req=0 for 20 cycles. Reset pulse -> pc=RESET_PC, halted=0, fetch resumes.
- Reset asserted while in EXEC of ADD R3 -> R3 remains 0 and imem_req=0 immediately. With CPU_RETIRE_CNT_EN, 10 instructions then HALT -> retire_cnt=11.
